// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between a CPU and a host program loader.
// Each access takes three cycles (IDLE, ISSUE, DONE). The host wins ties, except that
// after HOST_BURST_MAX consecutive host wins against a waiting CPU the CPU goes next.
// host_lock gives the host exclusive ownership.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned HOST_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned SW = $clog2(HOST_BURST_MAX + 1);
    localparam logic [SW-1:0] StreakMax = SW'(HOST_BURST_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e            state_q;
    logic [SW-1:0]     host_streak_q;
    logic [SW-1:0]     host_streak_d;
    logic              owner_cpu_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              cpu_gnt_q;
    logic              host_gnt_q;
    logic              cpu_ack_q;
    logic              host_ack_q;

    logic              cpu_win;
    logic              host_win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection and streak update; only consumed while in IDLE.
    always_comb begin
        cpu_win   = cpu_req && !host_lock && (!host_req || (host_streak_q == StreakMax));
        host_win  = host_req && !cpu_win;
        sel_we    = cpu_win ? cpu_we    : host_we;
        sel_addr  = cpu_win ? cpu_addr  : host_addr;
        sel_wdata = cpu_win ? cpu_wdata : host_wdata;

        host_streak_d = host_streak_q;
        if (!cpu_req || cpu_win) begin
            host_streak_d = '0;
        end else if (host_win && (host_streak_q != StreakMax)) begin
            host_streak_d = host_streak_q + 1'b1;
        end
    end

    // Access FSM with registered memory-side and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            host_streak_q <= '0;
            owner_cpu_q   <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            cpu_ack_q     <= 1'b0;
            host_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    host_streak_q <= host_streak_d;
                    if (cpu_win || host_win) begin
                        state_q     <= StIssue;
                        owner_cpu_q <= cpu_win;
                        we_q        <= sel_we;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        cpu_gnt_q   <= cpu_win;
                        host_gnt_q  <= host_win;
                    end
                end
                StIssue: begin
                    state_q     <= StDone;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    cpu_gnt_q   <= 1'b0;
                    host_gnt_q  <= 1'b0;
                    cpu_ack_q   <= owner_cpu_q;
                    host_ack_q  <= !owner_cpu_q;
                end
                StDone: begin
                    state_q    <= StIdle;
                    cpu_ack_q  <= 1'b0;
                    host_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Read data arrives from the memory during DONE, so it is steered rather than registered.
    always_comb begin
        cpu_rdata  = (cpu_ack_q && !we_q)  ? mem_rdata : '0;
        host_rdata = (host_ack_q && !we_q) ? mem_rdata : '0;
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign host_gnt  = host_gnt_q;
    assign cpu_ack   = cpu_ack_q;
    assign host_ack  = host_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       host_req, host_we, host_lock, host_gnt, host_ack;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       mem_en, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_gnt   (host_gnt),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM: write on enable+we, registered read otherwise.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One uncontended access starting from IDLE; called and returns at a falling edge.
    task automatic access(input bit is_cpu, input bit we, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        end
        @(negedge clk);
        check({tag, "_gnt"}, {30'd0, cpu_gnt, host_gnt}, is_cpu ? 32'd2 : 32'd1);
        check({tag, "_issue"}, {mem_en, mem_we, busy, mem_addr, mem_wdata},
              {8'd0, 1'b1, we, 1'b1, a, d});
        check({tag, "_ack0"}, {30'd0, cpu_ack, host_ack}, 32'd0);
        @(negedge clk);
        check({tag, "_ack"}, {30'd0, cpu_ack, host_ack}, is_cpu ? 32'd2 : 32'd1);
        check({tag, "_rdata"}, {16'd0, cpu_rdata, host_rdata},
              is_cpu ? {16'd0, exp_rd, 8'd0} : {24'd0, exp_rd});
        check({tag, "_done"}, {mem_en, mem_we, busy, cpu_gnt, host_gnt, mem_addr, mem_wdata},
              {11'd0, 5'b00100, 16'd0});
        cpu_req  = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {28'd0, busy, cpu_ack, host_ack, mem_en}, 32'd0);
    endtask

    logic [9:0] seq;
    int         gcount;
    int         last_c;
    int         both;
    int         cpu_g;

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hC3);
        mem[8'h10] = 8'h5A;
        mem[8'h05] = 8'hA5;
        mem_rdata  = 8'h00;

        // Reset state.
        @(negedge clk);
        check("reset_outs", {cpu_gnt, cpu_ack, cpu_rdata, host_gnt, host_ack, host_rdata,
                             mem_en, mem_we, busy}, 0);
        check("reset_mem", {16'd0, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        reset = 1'b0;

        // CPU read alone.
        access(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, "cpu_rd");
        // Host write then CPU read of the same location.
        access(1'b0, 1'b1, 8'h20, 8'h33, 8'h00, "host_wr");
        access(1'b1, 1'b0, 8'h20, 8'h00, 8'h33, "cpu_rd20");
        // Host read and CPU write round trip.
        access(1'b1, 1'b1, 8'h7E, 8'hE7, 8'h00, "cpu_wr");
        access(1'b0, 1'b0, 8'h7E, 8'h00, 8'hE7, "host_rd");

        // Fairness: both requesting continuously.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h41;
        host_req = 1; host_we = 0; host_addr = 8'h40;
        seq = '0; gcount = 0; last_c = -1; both = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cpu_gnt && host_gnt) both++;
            if (cpu_gnt || host_gnt) begin
                if (gcount < 10) seq[gcount] = cpu_gnt;
                gcount++;
                last_c = c;
            end
        end
        cpu_req = 0; host_req = 0;
        check("fair_order", {22'd0, seq}, 32'h210);
        check("fair_count", gcount, 10);
        check("fair_last_cycle", last_c, 27);
        check("fair_overlap", both, 0);
        @(negedge clk);
        check("fair_idle", {31'd0, busy}, 0);

        // Lock: host keeps ownership with CPU waiting.
        host_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        host_req = 1; host_we = 0; host_addr = 8'h40;
        gcount = 0; cpu_g = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cpu_gnt) cpu_g++;
            if (host_gnt) gcount++;
        end
        check("lock_cpu_gnts", cpu_g, 0);
        check("lock_host_gnts", gcount, 10);
        host_lock = 0;
        @(negedge clk);
        check("unlock_gnt", {30'd0, cpu_gnt, host_gnt}, 32'd2);
        host_req = 0;
        @(negedge clk);
        check("unlock_ack", {22'd0, cpu_ack, host_ack, cpu_rdata}, {22'd0, 2'b10, 8'h5A});
        cpu_req = 0;
        @(negedge clk);

        // Reset in the middle of a host write.
        host_req = 1; host_we = 1; host_addr = 8'h05; host_wdata = 8'h77;
        @(negedge clk);
        check("rst_pre_issue", {29'd0, mem_en, mem_we, host_gnt}, 32'd7);
        reset = 1'b1;
        host_req = 0;
        #1;
        check("rst_async", {28'd0, mem_en, mem_we, host_gnt, busy}, 0);
        @(negedge clk);
        check("rst_no_ack", {30'd0, host_ack, cpu_ack}, 0);
        reset = 1'b0;
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'hA5, "post_rst_rd");

        // Idle: nothing requested.
        both = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en || busy || cpu_gnt || host_gnt || cpu_ack || host_ack) both++;
        end
        check("idle_quiet", both, 0);
        check("idle_streak", {29'd0, dut.host_streak_q}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 8, address width; DATA_W, 8, data width; HOST_BURST_MAX, 4, consecutive host grants allowed while cpu_req is pending.
REQ-002 Ports (name, direction, width, meaning), one per line:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
cpu_req  in  1  CPU access request, level
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_ack  out  1  CPU access complete this cycle
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on a read
host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host (program loader) request, same meaning as CPU
host_lock  in  1  host exclusive ownership (program load)
host_gnt, host_ack, host_rdata  out  1/1/DATA_W  host equivalents of cpu_gnt/ack/rdata
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous read data, valid cycle after mem_en & !mem_we
busy  out  1  high in any state other than IDLE

Function
REQ-003 FSM states IDLE, ISSUE, DONE; transitions IDLE->ISSUE when a winner exists, ISSUE->DONE always, DONE->IDLE always; each access takes exactly 3 cycles (req seen in IDLE cycle N, gnt at N+1, ack at N+2).
REQ-004 At the IDLE->ISSUE edge, owner, we, addr and wdata of the winner are captured into registers; requester inputs are ignored outside IDLE.
REQ-005 ISSUE: mem_en=1, mem_we=captured we, mem_addr/mem_wdata=captured values, owner's gnt=1; all other cycles mem_en=mem_we=0, mem_addr/mem_wdata=0.
REQ-006 DONE: owner's ack=1; owner's rdata=mem_rdata if captured we=0, else 0; non-owner ack/rdata=0 always.
REQ-007 Arbitration in IDLE: only one requester -> it wins; both -> host wins unless host_streak==HOST_BURST_MAX, then CPU wins.
REQ-008 host_lock=1 -> CPU never wins regardless of host_streak; cpu_req stays pending without loss.
REQ-009 host_streak: +1 on each host win while cpu_req=1, saturating at HOST_BURST_MAX; cleared on a CPU win or in IDLE with cpu_req=0; width clog2(HOST_BURST_MAX+1).
REQ-010 Requesters hold req/we/addr/wdata stable until ack; req still high in the IDLE cycle after ack is a new request.
REQ-011 Write and read use identical timing; write data is committed at the ISSUE edge only.
REQ-012 No combinational path from any *_req input to mem_* outputs.

Reset
REQ-013 reset=1 immediately (asynchronously) forces state IDLE, host_streak=0, captured registers 0, and all outputs 0.
REQ-014 Reset during ISSUE deasserts mem_en/mem_we immediately; the access is aborted with no ack; after reset release, first possible gnt is 2 cycles later (IDLE then ISSUE).

Verification
REQ-015 CPU read alone: mem[0x10]=0x5A, cpu_req=1, cpu_we=0, cpu_addr=0x10 -> cpu_gnt at N+1 with mem_addr=0x10, cpu_ack at N+2 with cpu_rdata=0x5A, host_* outputs 0.
REQ-016 Host write then CPU read: host writes 0x33 to 0x20, then CPU reads 0x20 -> cpu_rdata=0x33; no overlap of mem_en between accesses.
REQ-017 Fairness: both req held continuously, host_lock=0, HOST_BURST_MAX=4 -> grant order H,H,H,H,C,H,H,H,H,C; each access 3 cycles.
REQ-018 Lock: host_lock=1, both req held for 10 host accesses -> zero cpu_gnt; drop host_lock -> CPU granted at next IDLE.
REQ-019 Reset mid-access: assert reset during ISSUE of a host write to 0x05 -> mem_en drops same cycle, no host_ack, busy=0; after release a CPU read of 0x05 returns its pre-write value.
REQ-020 Idle: no requests for 20 cycles -> mem_en, busy, all gnt/ack stay 0 and host_streak stays 0.
